// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU and its program loader:
// opcode encodings, loader geometry defaults and the loader state type.
package cpu_pkg;

    localparam logic [3:0] MOV = 4'h1;
    localparam logic [3:0] ADD = 4'h2;
    localparam logic [3:0] CMP = 4'h3;
    localparam logic [3:0] JE  = 4'h4;
    localparam logic [3:0] JNE = 4'h5;
    localparam logic [3:0] HLT = 4'h6;

    localparam int         LDR_DEPTH = 16;
    localparam int         LDR_AW    = 4;
    localparam int         LDR_DW    = 8;
    localparam logic [7:0] LDR_SYNC  = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } ldr_state_t;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the CPU instruction memory; keeps the CPU
// held in reset until a frame with a correct checksum has been written.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int              DEPTH = LDR_DEPTH,
    parameter int              AW    = LDR_AW,
    parameter int              DW    = LDR_DW,
    parameter logic [DW-1:0]   SYNC  = DW'(LDR_SYNC)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          load_done,
    output logic          load_err
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] MAX_LEN = DW'(DEPTH);

    // Handshake: a byte moves when in_valid && in_ready at a rising edge.
    // in_ready is a register derived from the next state, so it never
    // depends combinationally on in_valid.
    ldr_state_t    state_q, state_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q, addr_d;

    logic          xfer;
    logic          we_d;
    logic [AW-1:0] waddr_d;
    logic [DW-1:0] wdata_d;
    logic          hold_d;
    logic          ready_d;
    logic          busy_d;
    logic          done_d;
    logic          err_d;

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        waddr_d = mem_addr;
        wdata_d = mem_wdata;
        hold_d  = cpu_hold;

        case (state_q)
            IDLE: begin
                if (xfer && in_data == SYNC) begin
                    state_d = LEN;
                    hold_d  = 1'b1;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (in_data == '0 || in_data > MAX_LEN) begin
                        state_d = ERR;
                    end else begin
                        count_d = in_data[CW-1:0];
                        sum_d   = in_data;
                        addr_d  = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    sum_d   = sum_q + in_data;
                    addr_d  = addr_q + AW'(1);
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    if (in_data == sum_q) begin
                        state_d = DONE;
                        // Released together with the load_done pulse.
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == LEN) ||
                  (state_d == DATA) || (state_d == CHK);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sum_q     <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            in_ready  <= ready_d;
            mem_we    <= we_d;
            mem_addr  <= waddr_d;
            mem_wdata <= wdata_d;
            cpu_hold  <= hold_d;
            busy      <= busy_d;
            load_done <= done_d;
            load_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: good/bad frames, noise with
// stalls, reload and asynchronous reset in the middle of a frame.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       load_done;
    logic       load_err;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int hold_bad = 0;

    logic [11:0] obs_q[$];
    logic [11:0] exp_q[$];
    logic [7:0]  prog[12] = '{8'h11, 8'h03, 8'h12, 8'h03, 8'h21, 8'h31,
                              8'h06, 8'h40, 8'h0A, 8'h50, 8'h00, 8'h60};

    // Monitor: captures every write strobe and completion pulse mid-cycle.
    always @(negedge clk) begin
        if (mem_we) obs_q.push_back({mem_addr, mem_wdata});
        if (load_done) begin
            done_cnt++;
            if (cpu_hold) hold_bad++;
        end
        if (load_err) begin
            err_cnt++;
            if (!cpu_hold) hold_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int guard;
        if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("ready_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 30) chk({tag, "_idle_timeout"}, 32'(guard), 32'd0);
    endtask

    task automatic check_writes(input string tag, input int base);
        chk({tag, "_nwr"}, 32'(obs_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
            chk({tag, "_wr"}, 32'(obs_q[base + i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    // Sends A5 0C <prog> chk and checks the completion pulse latency.
    task automatic good_frame(input string tag, input logic [7:0] chk_byte, input bit good);
        int base, d0, e0;
        base = obs_q.size();
        d0   = done_cnt;
        e0   = err_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h0C, 1'b0);
        for (int i = 0; i < 12; i++) begin
            send_byte(prog[i], 1'b0);
            exp_q.push_back({4'(i), prog[i]});
            if (i == 0) begin
                chk({tag, "_we_lat"}, 32'(mem_we), 32'd1);
                chk({tag, "_addr0"}, 32'(mem_addr), 32'd0);
                chk({tag, "_data0"}, 32'(mem_wdata), 32'h11);
            end
        end
        send_byte(chk_byte, 1'b0);
        chk({tag, "_done_lat"}, 32'(load_done), 32'(good));
        chk({tag, "_err_lat"}, 32'(load_err), 32'(!good));
        chk({tag, "_hold_at_end"}, 32'(cpu_hold), 32'(!good));
        chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        wait_idle(tag);
        check_writes(tag, base);
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'(good));
        chk({tag, "_err_cnt"}, 32'(err_cnt - e0), 32'(!good));
        chk({tag, "_hold_after"}, 32'(cpu_hold), 32'(!good));
    endtask

    initial begin
        int base, d0, e0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);

        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_hold", 32'(cpu_hold), 32'd1);

        // Good frame, full rate; CHK = 0C + payload sum = 0x187 -> 87.
        good_frame("good", 8'h87, 1'b1);

        // Same frame with a wrong checksum.
        good_frame("badchk", 8'h88, 1'b0);

        // Bad lengths: 0 and DEPTH+1.
        base = obs_q.size();
        e0   = err_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("len0_err", 32'(load_err), 32'd1);
        wait_idle("len0");
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        chk("len17_err", 32'(load_err), 32'd1);
        wait_idle("len17");
        send_byte(8'h01, 1'b0);
        chk("after_badlen_idle", 32'(busy), 32'd0);
        check_writes("badlen", base);
        chk("badlen_err_cnt", 32'(err_cnt - e0), 32'd2);
        chk("badlen_hold", 32'(cpu_hold), 32'd1);

        // Noise then a 1-byte frame, with random stalls.
        base = obs_q.size();
        d0   = done_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        chk("noise_idle", 32'(busy), 32'd0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h60, 1'b1);
        exp_q.push_back({4'h0, 8'h60});
        send_byte(8'h61, 1'b1);
        chk("noise_done_lat", 32'(load_done), 32'd1);
        wait_idle("noise");
        check_writes("noise", base);
        chk("noise_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("noise_hold", 32'(cpu_hold), 32'd0);

        // Reload: a SYNC byte re-asserts hold in the following cycle.
        send_byte(8'hA5, 1'b0);
        chk("reload_hold", 32'(cpu_hold), 32'd1);
        chk("reload_busy", 32'(busy), 32'd1);

        // Continue into a frame and reset after the 5th payload byte.
        send_byte(8'h0C, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(prog[i], 1'b0);
        chk("mid_we", 32'(mem_we), 32'd1);
        chk("mid_addr", 32'(mem_addr), 32'd4);
        chk("mid_data", 32'(mem_wdata), 32'h21);
        reset = 1'b0;
        #1;
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_addr", 32'(mem_addr), 32'd0);
        chk("arst_wdata", 32'(mem_wdata), 32'd0);
        chk("arst_hold", 32'(cpu_hold), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_done", 32'(load_done), 32'd0);
        chk("arst_err", 32'(load_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        good_frame("after_rst", 8'h87, 1'b1);

        chk("hold_vs_pulse", 32'(hold_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the 16x8 instruction memory of the simple CPU and holds the CPU in reset until a valid image is present. It receives framed bytes over a valid/ready handshake, writes payload bytes to consecutive memory addresses starting at 0, and verifies an 8-bit checksum. It sits between the host link and the CPU's instruction memory write port. The CPU side is the memory reader and the loader is its writer.

## Interface
- `DEPTH`, 16, instruction memory words
- `AW`, 4, memory address width
- `DW`, 8, byte/word width
- `SYNC`, 8'hA5, frame start byte
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `in_data` in DW: incoming byte
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: loader accepts a byte this cycle; a transfer occurs when `in_valid && in_ready`
- `mem_we` out 1: instruction memory write strobe
- `mem_addr` out AW: write address
- `mem_wdata` out DW: write data
- `cpu_hold` out 1: holds the CPU in reset while high
- `busy` out 1: a frame is in progress (state not IDLE)
- `load_done` out 1: one-cycle pulse, frame accepted
- `load_err` out 1: one-cycle pulse, frame rejected

## Operation
- Frame format: `SYNC`, `LEN` (1..DEPTH), `LEN` payload bytes, `CHK`.
- `CHK` = (LEN + sum of payload bytes) mod 256.
- States:
  - IDLE: accepts bytes. A byte equal to `SYNC` moves to LEN. Any other byte is consumed and dropped.
  - LEN: on transfer, if `in_data` is 0 or greater than DEPTH, go to ERR. Otherwise latch the count, set sum = `in_data`, set address = 0, go to DATA.
  - DATA: on each transfer, write the byte to the current address, add it to the sum, and increment the address. After the LEN-th byte, go to CHK.
  - CHK: on transfer, go to DONE if `in_data` equals the sum, otherwise go to ERR.
  - DONE: one cycle. Pulse `load_done`, clear `cpu_hold`, return to IDLE.
  - ERR: one cycle. Pulse `load_err`, keep `cpu_hold` high, return to IDLE.
- `cpu_hold` behaviour:
  - Set by reset.
  - Set again when a `SYNC` byte is accepted in IDLE, so a reload always stops the CPU.
  - Cleared only in DONE.
- Memory words beyond LEN keep their previous contents.
- After ERR, bytes already written remain in memory, but `cpu_hold` stays high.
- Sum arithmetic is 8 bits and wraps. The address counter is AW bits and never wraps within a legal frame.
- `busy` is high in LEN, DATA, CHK, DONE and ERR.

## Timing
- `in_ready`: 1 in IDLE, LEN, DATA and CHK; 0 in DONE and ERR. It depends on state only, never combinationally on `in_valid`.
- All outputs are registered.
- Memory write latency: `mem_we`/`mem_addr`/`mem_wdata` are asserted the cycle after the payload byte transfer, for exactly one cycle.
- Completion latency:
  - The `load_done` or `load_err` pulse occurs the cycle after the CHK transfer (or the bad LEN transfer).
  - `cpu_hold` falls in the same cycle as `load_done`.
- Minimum frame time at full rate is LEN+3 transfers plus 1 completion cycle.
- `in_valid` low stalls any state without timeout.
- Reset values: `in_ready`=0 while `reset` is low, then 1 from the first cycle after release. `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `busy`=0, `load_done`=0, `load_err`=0. State resets to IDLE, sum and count to 0.
- Reset mid-frame: the frame is abandoned immediately, there is no partial write in flight after assertion, and `cpu_hold`=1.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants MOV=4'h1, ADD=4'h2, CMP=4'h3, JE=4'h4, JNE=4'h5, HLT=4'h6
  - the SYNC default
  - the loader state typedef (IDLE, LEN, DATA, CHK, DONE, ERR)
- A single flat module with no sub-module is the natural structure. The checksum is an 8-bit accumulator kept inline.

## Test plan
- Good frame, sent back-to-back:
  - Stimulus: A5, 0C, then payload 11 03 12 03 21 31 06 40 0A 50 00 60, then CHK 87.
  - Required: 12 writes to addresses 0..11 with matching data, `load_done` pulses once, `cpu_hold` falls, `load_err` stays 0.
- Bad checksum:
  - Stimulus: the same frame with CHK 88.
  - Required: 12 writes, `load_err` pulses, `cpu_hold` stays 1.
- Bad length:
  - Stimulus: A5 00, then A5 11.
  - Required: each gives `load_err` with no `mem_we`. The next byte is treated in IDLE.
- Noise before sync and stalls:
  - Stimulus: 00 FF 5A, then a good 1-byte frame A5 01 60 61, with `in_valid` toggling randomly.
  - Required: a single write of 60 to address 0, `load_done`, and the noise is ignored.
- Reload:
  - Stimulus: after a good load, send A5.
  - Required: `cpu_hold` rises the cycle after the A5 transfer.
- Reset mid-frame:
  - Stimulus: assert `reset` low after 5 payload bytes.
  - Required: all outputs return to reset values asynchronously. A following good frame loads normally.
